// File: rtl/uart_pkg.sv
// Shared UART types and baud-derived constants.
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    localparam int unsigned CYCLES_PER_BIT_115200 = 217;
    localparam int unsigned CYCLES_PER_BIT_9600   = 2604;
    localparam int unsigned BITS_PER_FRAME        = 10;
    localparam int unsigned TIMEOUT_MARGIN        = 1926;

    // Watchdog limit: one full frame plus slack for transmitter start-up.
    function automatic int unsigned timeout_for(input int unsigned cycles_per_bit);
        return BITS_PER_FRAME * cycles_per_bit + TIMEOUT_MARGIN;
    endfunction

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = timeout_for(CYCLES_PER_BIT_115200);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit after 'last', wrapping.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    int unsigned cand;

    // Scan N candidates starting just after the previous winner.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = (32'(last) + off) % N;
            if (!any_valid && valid[IW'(cand)]) begin
                any_valid          = 1'b1;
                grant[IW'(cand)]   = 1'b1;
                idx                = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned REQ_W          = $clog2(NUM_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [7:0]             o_tx_byte,
    output logic                   o_tx_dv,
    input  logic                   i_tx_active,
    input  logic                   i_tx_done,
    output logic [REQ_W-1:0]       o_grant_id,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t       state_q, state_d;
    logic [REQ_W-1:0] last_q, last_d;
    logic [REQ_W-1:0] gid_d;
    logic [7:0]       byte_d;
    logic             dv_d, busy_d, timeout_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [REQ_W-1:0]   pick_idx;
    logic               pick_any;
    logic               window;
    logic               accept;
    logic               expire;
    logic [7:0]         sel_byte;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .valid     (i_req_valid),
        .last      (last_q),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Arbitration window, handshake, watchdog expiry and winner byte mux.
    always_comb begin
        window   = ((state_q == ST_IDLE) && !i_tx_active) ||
                   ((state_q == ST_WAIT) && i_tx_done);
        accept   = window && pick_any;
        expire   = (state_q == ST_WAIT) && !i_tx_done &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        sel_byte = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == REQ_W'(k)) begin
                sel_byte = i_req_data[8*k +: 8];
            end
        end
    end

    assign o_req_ready = window ? pick_grant : '0;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = o_grant_id;
        byte_d    = o_tx_byte;
        dv_d      = 1'b0;
        busy_d    = o_busy;
        timeout_d = 1'b0;
        wd_d      = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    last_d  = pick_idx;
                    gid_d   = pick_idx;
                    byte_d  = sel_byte;
                    dv_d    = 1'b1;
                    busy_d  = 1'b1;
                    wd_d    = '0;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (accept) begin
                    last_d = pick_idx;
                    gid_d  = pick_idx;
                    byte_d = sel_byte;
                    dv_d   = 1'b1;
                    wd_d   = '0;
                end else if (i_tx_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_W'(NUM_REQ - 1);
            o_grant_id <= '0;
            o_tx_byte  <= '0;
            o_tx_dv    <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            o_grant_id <= gid_d;
            o_tx_byte  <= byte_d;
            o_tx_dv    <= dv_d;
            o_busy     <= busy_d;
            o_timeout  <= timeout_d;
            wd_q       <= wd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 4096;
    localparam int          FRAME   = 12;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    bit   have_done = 1'b0;
    bit   b2b_en = 1'b0;
    int   mode = 0;
    logic man_active = 1'b0;
    logic man_done = 1'b0;
    int   frame_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_tx_byte   (tx_byte),
        .o_tx_dv     (tx_dv),
        .i_tx_active (tx_active),
        .i_tx_done   (tx_done),
        .o_grant_id  (grant_id),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: manual (mode 0) or auto frame of FRAME cycles (mode 1).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mode == 0) begin
                tx_active = man_active;
                tx_done   = man_done;
                frame_cnt = 0;
            end else begin
                tx_done = 1'b0;
                if (frame_cnt != 0) begin
                    frame_cnt = frame_cnt - 1;
                    if (frame_cnt == 0) begin
                        tx_active = 1'b0;
                        tx_done   = 1'b1;
                    end
                end else if (tx_dv === 1'b1) begin
                    tx_active = 1'b1;
                    frame_cnt = FRAME;
                end
            end
        end
    end

    // Monitor: scoreboard on every dv, back-to-back timing, one-hot ready.
    always @(negedge clk) begin
        if (rst_n && tx_dv === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_dv: got byte %h id %0d, want no frame", tx_byte, grant_id);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_byte !== mon_e.data || grant_id !== mon_e.id) begin
                    errors++;
                    $display("FAIL sb_frame: got byte %h id %0d, want byte %h id %0d",
                             tx_byte, grant_id, mon_e.data, mon_e.id);
                end
            end
            if (b2b_en && have_done) begin
                checks++;
                if (cyc != last_done_cyc + 1) begin
                    errors++;
                    $display("FAIL b2b_latency: got dv at cycle %0d, want %0d", cyc, last_done_cyc + 1);
                end
            end
        end
        if (tx_done === 1'b1) begin
            last_done_cyc = cyc;
            have_done     = 1'b1;
        end
        if (rst_n && req_ready !== 4'b0000) begin
            checks++;
            if ($countones(req_ready) != 1) begin
                errors++;
                $display("FAIL ready_onehot: got %b, want exactly one bit", req_ready);
            end
        end
    end

    task automatic set_req(input int k, input logic v, input logic [7:0] d);
        req_valid[k]        = v;
        req_data[8*k +: 8]  = d;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] id);
        exp_t e;
        e.data = d;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic pulse_done;
        @(posedge clk); #1 man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        mode = 0;
        man_active = 1'b0;
        man_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({tx_byte, tx_dv, grant_id, busy, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got byte %h dv %b id %0d busy %b to %b, want all 0",
                     tx_byte, tx_dv, grant_id, busy, timeout);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 0000", req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        push_exp(8'h41, 2'd0);
        @(posedge clk); #1 set_req(0, 1'b1, 8'h41);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b, want 0001", req_ready);
        end
        @(posedge clk); #1 set_req(0, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_dv: got dv %b busy %b id %0d, want 1 1 0", tx_dv, busy, grant_id);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b0 || tx_byte !== 8'h41) begin
            errors++;
            $display("FAIL single_hold: got dv %b byte %h, want 0 41", tx_dv, tx_byte);
        end
        pulse_done();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy %b, want 0", busy);
        end
    endtask

    task automatic test_round_robin;
        int n;
        apply_reset();
        rst_n = 1'b1;
        mode = 1;
        have_done = 1'b0;
        b2b_en = 1'b1;
        push_exp(8'hA0, 2'd0);
        push_exp(8'hA1, 2'd1);
        push_exp(8'hA2, 2'd2);
        push_exp(8'hA3, 2'd3);
        push_exp(8'hA0, 2'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'hA0 + 8'(k));
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 req_valid = '0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_frames: got %0d frames pending, want 0", exp_q.size());
        end
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got busy %b, want 0", busy);
        end
        b2b_en = 1'b0;
        mode = 0;
    endtask

    task automatic test_inflight;
        push_exp(8'h11, 2'd0);
        push_exp(8'h5A, 2'd2);
        @(posedge clk); #1 set_req(0, 1'b1, 8'h11);
        @(posedge clk); #1 set_req(0, 1'b0, 8'h00);
        @(posedge clk); #1 set_req(2, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL inflight_blocked: got %b, want 0000", req_ready);
            end
            @(posedge clk);
        end
        #1 man_done = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL inflight_ready: got %b, want 0100", req_ready);
        end
        @(posedge clk); #1;
        man_done = 1'b0;
        set_req(2, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'h5A || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL inflight_dv: got dv %b byte %h id %0d, want 1 5a 2", tx_dv, tx_byte, grant_id);
        end
        pulse_done();
    endtask

    task automatic test_timeout;
        int n;
        push_exp(8'h77, 2'd0);
        push_exp(8'h33, 2'd1);
        @(posedge clk); #1 set_req(0, 1'b1, 8'h77);
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00);
        set_req(1, 1'b1, 8'h33);
        @(negedge clk);
        n = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && n < int'(TIMEOUT) + 50) begin
            @(posedge clk);
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n != int'(TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_dwell: got %0d busy cycles, want %0d", n, TIMEOUT);
        end
        checks++;
        if (timeout !== 1'b1 || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_pulse: got to %b ready %b, want 1 0010", timeout, req_ready);
        end
        @(posedge clk); #1 set_req(1, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || tx_dv !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL timeout_regrant: got to %b dv %b id %0d, want 0 1 1", timeout, tx_dv, grant_id);
        end
        pulse_done();
    endtask

    task automatic test_reset_midframe;
        push_exp(8'h22, 2'd2);
        @(posedge clk); #1 set_req(2, 1'b1, 8'h22);
        @(posedge clk); #1;
        set_req(2, 1'b0, 8'h00);
        set_req(3, 1'b1, 8'h99);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL midframe_busy: got busy %b id %0d, want 1 2", busy, grant_id);
        end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_byte, tx_dv, grant_id, busy, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL midframe_async: got byte %h dv %b id %0d busy %b, want all 0",
                     tx_byte, tx_dv, grant_id, busy);
        end
        push_exp(8'h44, 2'd0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h44);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midframe_prio: got %b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00);
        set_req(3, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midframe_grant: got dv %b id %0d, want 1 0", tx_dv, grant_id);
        end
        pulse_done();
    endtask

    task automatic test_active_block;
        @(posedge clk); #1 man_active = 1'b1;
        push_exp(8'h66, 2'd1);
        @(posedge clk); #1 set_req(1, 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || tx_dv !== 1'b0) begin
                errors++;
                $display("FAIL active_block: got ready %b dv %b, want 0000 0", req_ready, tx_dv);
            end
            @(posedge clk);
        end
        #1 man_active = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL active_release: got %b, want 0010", req_ready);
        end
        @(posedge clk); #1 set_req(1, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL active_grant: got dv %b id %0d, want 1 1", tx_dv, grant_id);
        end
        pulse_done();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL active_idle: got busy %b, want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_inflight();
        test_timeout();
        test_reset_midframe();
        test_active_block();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames never issued, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
